// File: rtl/puf_reader_pkg.sv
// Shared types and derived constants for the PUF response reader.
// The build macro PUF_MAJORITY_VOTE_EN selects the number of read passes.
package puf_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int PUF_BLOCKS_DEFAULT = 2;

  function automatic int calc_puf_bits(input int blocks);
    return blocks * 32;
  endfunction

  function automatic int calc_puf_bytes(input int blocks);
    return (blocks * 32) / 8;
  endfunction

  // The address port keeps at least one bit even for a single-byte PUF.
  function automatic int calc_addr_w(input int blocks);
    int bytes;
    bytes = (blocks * 32) / 8;
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

  localparam int PUF_BITS  = calc_puf_bits(PUF_BLOCKS_DEFAULT);
  localparam int PUF_BYTES = calc_puf_bytes(PUF_BLOCKS_DEFAULT);
  localparam int ADDR_W    = calc_addr_w(PUF_BLOCKS_DEFAULT);

`ifdef PUF_MAJORITY_VOTE_EN
  localparam int NUM_PASSES = 3;
`else
  localparam int NUM_PASSES = 1;
`endif

  localparam int PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

endpackage

// File: rtl/puf_majority3.sv
// Per-bit 3-input majority vote across three captured PUF passes.
module puf_majority3
  import puf_reader_pkg::*;
#(
  parameter int WIDTH = PUF_BITS
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] y
);

  // A bit is set when at least two of the three passes agree on 1.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign y[gi] = (a[gi] & b[gi]) | (a[gi] & c[gi]) | (b[gi] & c[gi]);
    end
  endgenerate

endmodule

// File: rtl/puf_response_reader.sv
// PUF response reader: clocks every byte out of the external PUF and
// assembles them into one response word for the fuzzy extractor.
// Build macro PUF_MAJORITY_VOTE_EN: read the PUF three times and return
// the bitwise majority; otherwise a single pass is returned directly.
module puf_response_reader
  import puf_reader_pkg::*;
#(
  parameter int PUF_BLOCKS      = 2,
  parameter int PUF_HALF_PERIOD = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  output logic                                 puf_clk,
  output logic                                 puf_enable,
  output logic [calc_addr_w(PUF_BLOCKS)-1:0]   puf_addr,
  input  logic [7:0]                           puf_data,
  output logic                                 busy,
  output logic                                 response_valid,
  output logic [calc_puf_bits(PUF_BLOCKS)-1:0] puf_response
);

  localparam int RESP_W   = calc_puf_bits(PUF_BLOCKS);
  localparam int BYTE_CNT = calc_puf_bytes(PUF_BLOCKS);
  localparam int AW       = calc_addr_w(PUF_BLOCKS);
  localparam int HP_W     = $clog2(PUF_HALF_PERIOD + 1);

  state_e              state_q, state_d;
  logic [HP_W-1:0]     hp_cnt_q, hp_cnt_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [PASS_W-1:0]   pass_q, pass_d;
  logic [RESP_W-1:0]   acc_q [NUM_PASSES];
  logic [RESP_W-1:0]   acc_d [NUM_PASSES];
  logic [RESP_W-1:0]   vote_result;

  logic                puf_clk_q, puf_clk_d;
  logic                puf_enable_q, puf_enable_d;
  logic [AW-1:0]       puf_addr_q, puf_addr_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic [RESP_W-1:0]   resp_q, resp_d;

  logic hp_last, idx_last, pass_last;

  assign hp_last   = (hp_cnt_q == HP_W'(PUF_HALF_PERIOD - 1));
  assign idx_last  = (idx_q == AW'(BYTE_CNT - 1));
  assign pass_last = (pass_q == PASS_W'(NUM_PASSES - 1));

  // State, counters and all outputs are registered so every port is glitch free.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      hp_cnt_q     <= '0;
      idx_q        <= '0;
      pass_q       <= '0;
      puf_clk_q    <= 1'b0;
      puf_enable_q <= 1'b0;
      puf_addr_q   <= '0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      resp_q       <= '0;
    end else begin
      state_q      <= state_d;
      hp_cnt_q     <= hp_cnt_d;
      idx_q        <= idx_d;
      pass_q       <= pass_d;
      puf_clk_q    <= puf_clk_d;
      puf_enable_q <= puf_enable_d;
      puf_addr_q   <= puf_addr_d;
      busy_q       <= busy_d;
      valid_q      <= valid_d;
      resp_q       <= resp_d;
    end
  end

  // One accumulator per pass; each is cleared whenever the reader is idle.
  generate
    for (genvar gi = 0; gi < NUM_PASSES; gi++) begin : g_acc
      always_ff @(posedge clk) begin
        if (!reset) begin
          acc_q[gi] <= '0;
        end else begin
          acc_q[gi] <= acc_d[gi];
        end
      end
    end
  endgenerate

  // Next-state logic: half-period timing, byte/pass sequencing and byte capture.
  always_comb begin
    state_d  = state_q;
    hp_cnt_d = hp_cnt_q + HP_W'(1);
    idx_d    = idx_q;
    pass_d   = pass_q;
    acc_d    = acc_q;
    case (state_q)
      IDLE: begin
        hp_cnt_d = '0;
        idx_d    = '0;
        pass_d   = '0;
        for (int p = 0; p < NUM_PASSES; p++) begin
          acc_d[p] = '0;
        end
        if (start) begin
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (hp_last) begin
          state_d  = HIGH;
          hp_cnt_d = '0;
        end
      end
      HIGH: begin
        if (hp_last) begin
          hp_cnt_d = '0;
          // The PUF byte has been stable since the puf_clk rise; take it now.
          for (int p = 0; p < NUM_PASSES; p++) begin
            if (PASS_W'(p) == pass_q) begin
              acc_d[p][8*idx_q +: 8] = puf_data;
            end
          end
          if (!idx_last) begin
            idx_d   = idx_q + AW'(1);
            state_d = SETUP;
          end else if (!pass_last) begin
            idx_d   = '0;
            pass_d  = pass_q + PASS_W'(1);
            state_d = SETUP;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        hp_cnt_d = '0;
        state_d  = IDLE;
      end
      default: begin
        hp_cnt_d = '0;
        state_d  = IDLE;
      end
    endcase
  end

`ifdef PUF_MAJORITY_VOTE_EN
  puf_majority3 #(
    .WIDTH (RESP_W)
  ) u_vote (
    .a (acc_d[0]),
    .b (acc_d[1]),
    .c (acc_d[2]),
    .y (vote_result)
  );
`else
  assign vote_result = acc_d[0];
`endif

  // Output decode from the upcoming state; the response word only changes on DONE entry.
  always_comb begin
    puf_clk_d    = (state_d == HIGH);
    puf_enable_d = (state_d == SETUP) || (state_d == HIGH);
    puf_addr_d   = puf_enable_d ? idx_d : '0;
    busy_d       = (state_d != IDLE);
    valid_d      = (state_d == DONE);
    resp_d       = (state_d == DONE) ? vote_result : resp_q;
  end

  assign puf_clk        = puf_clk_q;
  assign puf_enable     = puf_enable_q;
  assign puf_addr       = puf_addr_q;
  assign busy           = busy_q;
  assign response_valid = valid_q;
  assign puf_response   = resp_q;

endmodule

// File: tb/tb_puf_response_reader.sv
// Testbench for puf_response_reader: a half-period-1 instance (a) and a
// half-period-3 instance (b), each with its own behavioural PUF model.
module tb_puf_response_reader;

  localparam int BYTES = 8;
`ifdef PUF_MAJORITY_VOTE_EN
  localparam int TB_PASSES = 3;
`else
  localparam int TB_PASSES = 1;
`endif
  localparam int HP_A  = 1;
  localparam int HP_B  = 3;
  localparam int LAT_A = 1 + 2 * HP_A * BYTES * TB_PASSES;
  localparam int LAT_B = 1 + 2 * HP_B * BYTES * TB_PASSES;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;

  logic        puf_clk_a, puf_enable_a, busy_a, valid_a;
  logic [2:0]  puf_addr_a;
  logic [7:0]  puf_data_a = 8'h00;
  logic [63:0] resp_a;

  logic        puf_clk_b, puf_enable_b, busy_b, valid_b;
  logic [2:0]  puf_addr_b;
  logic [7:0]  puf_data_b = 8'h00;
  logic [63:0] resp_b;

  logic [7:0]  mem [BYTES];
  logic [63:0] q_a [$];
  logic [63:0] q_b [$];

  int checks = 0;
  int errors = 0;
  int rise_a = 0;
  int rise_b = 0;

  always #5 clk = ~clk;

  puf_response_reader #(.PUF_BLOCKS(2), .PUF_HALF_PERIOD(HP_A)) dut_a (
    .clk            (clk),
    .reset          (reset),
    .start          (start_a),
    .puf_clk        (puf_clk_a),
    .puf_enable     (puf_enable_a),
    .puf_addr       (puf_addr_a),
    .puf_data       (puf_data_a),
    .busy           (busy_a),
    .response_valid (valid_a),
    .puf_response   (resp_a)
  );

  puf_response_reader #(.PUF_BLOCKS(2), .PUF_HALF_PERIOD(HP_B)) dut_b (
    .clk            (clk),
    .reset          (reset),
    .start          (start_b),
    .puf_clk        (puf_clk_b),
    .puf_enable     (puf_enable_b),
    .puf_addr       (puf_addr_b),
    .puf_data       (puf_data_b),
    .busy           (busy_b),
    .response_valid (valid_b),
    .puf_response   (resp_b)
  );

  // PUF model: registered byte on each puf_clk rise; the second pass returns a
  // corrupted byte 3 so the majority vote has something to out-vote.
  always @(posedge puf_clk_a or negedge puf_enable_a) begin
    if (!puf_enable_a) begin
      rise_a <= 0;
    end else begin
      puf_data_a <= ((rise_a / BYTES) == 1 && puf_addr_a == 3'd3) ? 8'h62 : mem[puf_addr_a];
      rise_a     <= rise_a + 1;
    end
  end

  always @(posedge puf_clk_b or negedge puf_enable_b) begin
    if (!puf_enable_b) begin
      rise_b <= 0;
    end else begin
      puf_data_b <= ((rise_b / BYTES) == 1 && puf_addr_b == 3'd3) ? 8'h62 : mem[puf_addr_b];
      rise_b     <= rise_b + 1;
    end
  end

  function automatic logic [63:0] model_response();
    logic [63:0] r;
    for (int i = 0; i < BYTES; i++) r[8*i +: 8] = mem[i];
    return r;
  endfunction

  task automatic load_default_mem();
    mem[0] = 8'h24; mem[1] = 8'h81; mem[2] = 8'h09; mem[3] = 8'h63;
    mem[4] = 8'h0D; mem[5] = 8'h8D; mem[6] = 8'h65; mem[7] = 8'h12;
  endtask

  // Leaves the bench #1 after the edge that samples start.
  task automatic pulse_start(input bit use_b);
    @(posedge clk); #1;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Sample k is taken #1 after edge k; cycle k+1 spans edges k..k+1.
  task automatic wait_valid_a(input int limit, output int lat, output bit got);
    got = 1'b0;
    lat = 0;
    for (int k = 0; k < limit; k++) begin
      if (valid_a) begin
        got = 1'b1;
        lat = k + 1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (puf_clk_a !== 1'b0) begin errors++; $display("FAIL reset_puf_clk: got %b want 0", puf_clk_a); end
    checks++; if (puf_enable_a !== 1'b0) begin errors++; $display("FAIL reset_puf_enable: got %b want 0", puf_enable_a); end
    checks++; if (puf_addr_a !== 3'd0) begin errors++; $display("FAIL reset_puf_addr: got %0d want 0", puf_addr_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_a); end
    checks++; if (resp_a !== 64'd0) begin errors++; $display("FAIL reset_response: got %h want 0", resp_a); end
    checks++; if (puf_enable_b !== 1'b0 || busy_b !== 1'b0) begin errors++; $display("FAIL reset_b_outputs: got en=%b busy=%b want 0 0", puf_enable_b, busy_b); end
    reset = 1'b1;
    $display("reset: outputs sampled after reset");
  endtask

  task automatic test_single_read();
    int en_cycles = 0;
    int busy_low = 0;
    int addr_moves = 0;
    int exp_addr = 0;
    int lat = 0;
    bit got = 1'b0;
    logic prev_clk = 1'b0;
    logic [2:0] held = 3'd0;
    logic [63:0] exp;
    q_a.push_back(model_response());
    pulse_start(1'b0);
    for (int k = 0; k < 400; k++) begin
      if (valid_a) begin got = 1'b1; lat = k + 1; break; end
      if (puf_enable_a) en_cycles++;
      if (!busy_a) busy_low++;
      if (puf_clk_a && !prev_clk) begin
        checks++;
        if (puf_addr_a !== 3'(exp_addr)) begin
          errors++; $display("FAIL addr_step: got %0d want %0d", puf_addr_a, exp_addr);
        end
        held = puf_addr_a;
        exp_addr = (exp_addr + 1) % BYTES;
      end else if (puf_clk_a && puf_addr_a !== held) begin
        addr_moves++;
      end
      prev_clk = puf_clk_a;
      @(posedge clk); #1;
    end
    checks++; if (!got) begin errors++; $display("FAIL single_timeout: got no response_valid want one within 400 cycles"); end
    checks++; if (lat != LAT_A) begin errors++; $display("FAIL single_latency: got %0d want %0d", lat, LAT_A); end
    exp = q_a.pop_front();
    checks++; if (resp_a !== exp) begin errors++; $display("FAIL single_response: got %h want %h", resp_a, exp); end
    checks++; if (en_cycles != 2 * HP_A * BYTES * TB_PASSES) begin errors++; $display("FAIL enable_cycles: got %0d want %0d", en_cycles, 2 * HP_A * BYTES * TB_PASSES); end
    checks++; if (addr_moves != 0) begin errors++; $display("FAIL addr_stable_high: got %0d changes want 0", addr_moves); end
    checks++; if (busy_low != 0) begin errors++; $display("FAIL busy_during_read: got %0d low cycles want 0", busy_low); end
    checks++; if (busy_a !== 1'b1 || puf_enable_a !== 1'b0 || puf_clk_a !== 1'b0) begin
      errors++; $display("FAIL done_outputs: got busy=%b en=%b clk=%b want 1 0 0", busy_a, puf_enable_a, puf_clk_a);
    end
    $display("read a: latency=%0d response=%h", lat, resp_a);
    @(posedge clk); #1;
    checks++; if (valid_a !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("FAIL after_done: got valid=%b busy=%b want 0 0", valid_a, busy_a); end
    checks++; if (resp_a !== exp) begin errors++; $display("FAIL response_hold: got %h want %h", resp_a, exp); end
  endtask

  task automatic test_start_while_busy();
    int pulses = 0;
    int first = 0;
    int busy_after = 0;
    logic [63:0] exp;
    q_a.push_back(model_response());
    exp = 64'd0;
    pulse_start(1'b0);
    for (int k = 0; k < LAT_A + 12; k++) begin
      if (k == 4) start_a = 1'b1;
      if (k == 5) start_a = 1'b0;
      if (valid_a) begin
        pulses++;
        if (pulses == 1) begin
          first = k + 1;
          exp = q_a.pop_front();
          checks++; if (resp_a !== exp) begin errors++; $display("FAIL busy_start_response: got %h want %h", resp_a, exp); end
          $display("read a: latency=%0d response=%h (start repeated mid-read)", first, resp_a);
          start_a = 1'b1;
        end
      end else if (pulses == 1) begin
        start_a = 1'b0;
        if (busy_a) busy_after++;
      end
      @(posedge clk); #1;
    end
    start_a = 1'b0;
    checks++; if (pulses != 1) begin errors++; $display("FAIL busy_start_pulses: got %0d want 1", pulses); end
    checks++; if (first != LAT_A) begin errors++; $display("FAIL busy_start_latency: got %0d want %0d", first, LAT_A); end
    checks++; if (busy_after != 0) begin errors++; $display("FAIL done_start_ignored: got %0d busy cycles want 0", busy_after); end
  endtask

  task automatic test_reset_mid();
    int lat = 0;
    bit got = 1'b0;
    int pulses = 0;
    logic [63:0] exp;
    pulse_start(1'b0);
    repeat (7) begin @(posedge clk); #1; end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (puf_enable_a !== 1'b0 || puf_clk_a !== 1'b0) begin errors++; $display("FAIL midreset_puf: got en=%b clk=%b want 0 0", puf_enable_a, puf_clk_a); end
    checks++; if (busy_a !== 1'b0 || valid_a !== 1'b0 || resp_a !== 64'd0) begin
      errors++; $display("FAIL midreset_outputs: got busy=%b valid=%b resp=%h want 0 0 0", busy_a, valid_a, resp_a);
    end
    reset = 1'b1;
    for (int k = 0; k < 25; k++) begin
      if (valid_a) pulses++;
      @(posedge clk); #1;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL midreset_no_valid: got %0d pulses want 0", pulses); end
    q_a.push_back(model_response());
    pulse_start(1'b0);
    wait_valid_a(400, lat, got);
    checks++; if (!got || lat != LAT_A) begin errors++; $display("FAIL restart_latency: got %0d (seen=%b) want %0d", lat, got, LAT_A); end
    exp = q_a.pop_front();
    checks++; if (resp_a !== exp) begin errors++; $display("FAIL restart_response: got %h want %h", resp_a, exp); end
    $display("read a: latency=%0d response=%h (after mid-read reset)", lat, resp_a);
  endtask

  task automatic test_back_to_back();
    int lat = 0;
    bit got = 1'b0;
    logic [63:0] exp;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < BYTES; i++) mem[i] = 8'($urandom_range(0, 255));
      if (r == 2) for (int i = 0; i < BYTES; i++) mem[i] = 8'hFF - 8'(i);
      q_a.push_back(model_response());
      pulse_start(1'b0);
      wait_valid_a(400, lat, got);
      checks++; if (!got || lat != LAT_A) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d (seen=%b) want %0d", r, lat, got, LAT_A); end
      exp = q_a.pop_front();
      checks++; if (resp_a !== exp) begin errors++; $display("FAIL b2b_response[%0d]: got %h want %h", r, resp_a, exp); end
      $display("read a: latency=%0d response=%h (pattern %0d)", lat, resp_a, r);
      @(posedge clk); #1;
    end
    load_default_mem();
  endtask

  task automatic test_majority_byte();
    int lat = 0;
    bit got = 1'b0;
    logic [63:0] exp;
    q_a.push_back(model_response());
    pulse_start(1'b0);
    wait_valid_a(400, lat, got);
    exp = q_a.pop_front();
    checks++; if (!got || resp_a[31:24] !== exp[31:24]) begin errors++; $display("FAIL vote_byte3: got %h want %h", resp_a[31:24], exp[31:24]); end
    checks++; if (lat != LAT_A) begin errors++; $display("FAIL vote_latency: got %0d want %0d", lat, LAT_A); end
    $display("read a: latency=%0d response=%h (pass-2 byte 3 corrupted)", lat, resp_a);
  endtask

  task automatic test_half_period3();
    int lat = 0;
    bit got = 1'b0;
    int rise1 = -1;
    int rise2 = -1;
    logic prev_clk = 1'b0;
    logic [63:0] exp;
    q_b.push_back(model_response());
    pulse_start(1'b1);
    for (int k = 0; k < 600; k++) begin
      if (valid_b) begin got = 1'b1; lat = k + 1; break; end
      if (puf_clk_b && !prev_clk) begin
        if (rise1 < 0) rise1 = k; else if (rise2 < 0) rise2 = k;
      end
      prev_clk = puf_clk_b;
      @(posedge clk); #1;
    end
    checks++; if (rise2 - rise1 != 2 * HP_B) begin errors++; $display("FAIL hp3_period: got %0d want %0d", rise2 - rise1, 2 * HP_B); end
    checks++; if (!got || lat != LAT_B) begin errors++; $display("FAIL hp3_latency: got %0d (seen=%b) want %0d", lat, got, LAT_B); end
    exp = q_b.pop_front();
    checks++; if (resp_b !== exp) begin errors++; $display("FAIL hp3_response: got %h want %h", resp_b, exp); end
    $display("read b: latency=%0d response=%h", lat, resp_b);
  endtask

  initial begin
    load_default_mem();
    test_reset();
    test_single_read();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    test_majority_byte();
    test_half_period3();
    checks++; if (q_a.size() != 0 || q_b.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d/%0d pending want 0/0", q_a.size(), q_b.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/puf_response_reader.md
Name: puf_response_reader

Overview:
- Upstream stage of secure_key_system: drives the external PUF clocked-read interface, fetches all PUF bytes, and assembles them into one PUF_BITS-wide response word.
- The assembled word feeds the fuzzy extractor.
- Generates puf_clk from the system clock and sequences puf_enable / puf_addr.
- Captures the registered byte returned after each puf_clk rising edge.

Parameters:
- PUF_BLOCKS, 2, number of 32-bit PUF blocks; PUF_BITS = PUF_BLOCKS*32, PUF_BYTES = PUF_BITS/8.
- PUF_HALF_PERIOD, 1, clk cycles per puf_clk half-period; legal range is 1 or more.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset; synchronous, active-low (0 = reset).
- start  in  1  one-cycle request to read the full PUF; ignored while busy.
- puf_clk  out  1  generated PUF clock, driven from a register.
- puf_enable  out  1  high for the whole read sequence.
- puf_addr  out  max(1,$clog2(PUF_BYTES))  current byte address.
- puf_data  in  8  byte returned by the PUF, updated on puf_clk rise.
- busy  out  1  high from the cycle after start is accepted until the cycle after response_valid.
- response_valid  out  1  one-cycle pulse; puf_response is valid.
- puf_response  out  PUF_BITS  byte i occupies bits [8i+7:8i].

Behaviour:
- Reset values (reset==0 at a clk edge): state IDLE; all outputs 0. This includes puf_clk, puf_enable, puf_addr, busy, response_valid and puf_response.
- State IDLE: puf_clk=0, puf_enable=0.
  - start=1 → SETUP.
  - idx=0, half-period counter=0, accumulator cleared.
- State SETUP: puf_enable=1, puf_addr=idx, puf_clk=0.
  - Held for PUF_HALF_PERIOD cycles, then → HIGH.
  - puf_clk rises on entry to HIGH.
- State HIGH: puf_clk=1 for PUF_HALF_PERIOD cycles.
  - On the clk edge ending the last HIGH cycle, accumulator[8*idx +: 8] <= puf_data.
  - If idx==PUF_BYTES-1 → DONE; otherwise idx+1 → SETUP.
  - puf_addr never changes while puf_clk=1.
- State DONE: one cycle.
  - puf_enable=0, puf_clk=0, response_valid=1.
  - puf_response <= accumulator, loaded on the edge entering DONE; then → IDLE.
- puf_response holds its value until the next DONE or reset. It is never partially updated during a read.
- Latency: response_valid is asserted 1 + 2*PUF_HALF_PERIOD*PUF_BYTES cycles after the edge that samples start (17 cycles for the defaults).
- Boundary conditions:
  - start while busy: ignored, no restart.
  - start in the DONE cycle: ignored.
  - reset mid-sequence: immediate return to IDLE. puf_enable and puf_clk drop the next cycle, and no response_valid is issued.
  - puf_addr wraps only by restart, never by counting.
  - puf_addr width is at least 1 bit when PUF_BYTES==1.
- Half-period counter: width $clog2(PUF_HALF_PERIOD+1), cleared on every state change.

Optional Feature:
- Macro: PUF_MAJORITY_VOTE_EN.
- Defined:
  - The full byte sequence is performed 3 times back-to-back, with puf_enable held high and puf_clk continuous between passes.
  - Each pass is captured into its own accumulator.
  - In DONE, puf_response = bitwise majority of the 3 passes.
  - Latency becomes 1 + 6*PUF_HALF_PERIOD*PUF_BYTES (49 for the defaults).
- Undefined: single pass as described above; the extra accumulators are absent.
- Ports are identical in both builds.

Decomposition:
- Package puf_reader_pkg holds:
  - the state enum (IDLE, SETUP, HIGH, DONE);
  - the derived constants PUF_BITS, PUF_BYTES, ADDR_W;
  - the pass-count constant (1, or 3 under the macro).
- One sub-module, puf_majority3: a combinational per-bit 3-input majority of width PUF_BITS. It is instantiated only under PUF_MAJORITY_VOTE_EN.

Test Plan:
- Reset, then start=1 with the PUF model loaded with bytes 0x24,0x81,0x09,0x63,0x0D,0x8D,0x65,0x12 → response_valid at cycle 17; puf_response=0x12658D0D63098124; busy drops 1 cycle later.
- Address sequence check, same run → puf_addr steps 0..7, each stable across the whole puf_clk high phase; puf_enable high for exactly 16 cycles.
- start pulsed again at cycle 5 of a read → ignored; single response_valid at cycle 17; value unchanged.
- reset=0 at cycle 8 of a read → outputs 0 the next cycle; no response_valid; a new start yields the correct response after 17 cycles.
- PUF_HALF_PERIOD=3 → puf_clk period 6 cycles; response_valid at cycle 49; same response value.
- PUF_MAJORITY_VOTE_EN with the model flipping byte 3 to 0x62 on pass 2 only → puf_response byte 3 = 0x63; valid at cycle 49.
